// File: rtl/scc_bus_arbiter.sv
// Two-requester arbiter for the scc_for_ocm register/wave-RAM bus port, with ack timeout.
// Define SCC_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise requester A has fixed priority.
module scc_bus_arbiter #(
    parameter int GAP_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk21m,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_wrt,
    input  logic [15:0] a_adr,
    input  logic [7:0]  a_dbo,
    output logic        a_ack,
    output logic [7:0]  a_dbi,
    input  logic        b_req,
    input  logic        b_wrt,
    input  logic [15:0] b_adr,
    input  logic [7:0]  b_dbo,
    output logic        b_ack,
    output logic [7:0]  b_dbi,
    output logic        s_req,
    output logic        s_wrt,
    output logic [15:0] s_adr,
    output logic [7:0]  s_dbo,
    input  logic        s_ack,
    input  logic [7:0]  s_dbi,
    output logic        grant_b,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_ACK, ST_GAP} state_t;

    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic        s_req_q, s_req_d;
    logic        s_wrt_q, s_wrt_d;
    logic [15:0] s_adr_q, s_adr_d;
    logic [7:0]  s_dbo_q, s_dbo_d;
    logic        a_ack_q, a_ack_d;
    logic        b_ack_q, b_ack_d;
    logic [7:0]  a_dbi_q, a_dbi_d;
    logic [7:0]  b_dbi_q, b_dbi_d;
    logic        grant_b_q, grant_b_d;
    logic        timeout_err_q, timeout_err_d;
    logic [9:0]  tmo_cnt_q, tmo_cnt_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic        pick_b;
    logic        finish;
    logic [7:0]  finish_data;

`ifdef SCC_ARB_ROUND_ROBIN_EN
    logic last_b_q, last_b_d;

    // On a tie, the requester that was not served last wins.
    assign pick_b = b_req & (~a_req | ~last_b_q);

    always_comb begin
        last_b_d = last_b_q;
        if (state_q == ST_IDLE && (a_req || b_req)) begin
            last_b_d = pick_b;
        end
    end

    always_ff @(posedge clk21m) begin
        if (reset) begin
            last_b_q <= 1'b1;
        end else begin
            last_b_q <= last_b_d;
        end
    end
`else
    assign pick_b = b_req & ~a_req;
`endif

    always_comb begin
        state_d       = state_q;
        s_req_d       = s_req_q;
        s_wrt_d       = s_wrt_q;
        s_adr_d       = s_adr_q;
        s_dbo_d       = s_dbo_q;
        a_ack_d       = 1'b0;
        b_ack_d       = 1'b0;
        a_dbi_d       = a_dbi_q;
        b_dbi_d       = b_dbi_q;
        grant_b_d     = grant_b_q;
        timeout_err_d = 1'b0;
        tmo_cnt_d     = tmo_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        finish        = 1'b0;
        finish_data   = s_dbi;

        case (state_q)
            ST_IDLE: begin
                if (a_req || b_req) begin
                    grant_b_d = pick_b;
                    s_wrt_d   = pick_b ? b_wrt : a_wrt;
                    s_adr_d   = pick_b ? b_adr : a_adr;
                    s_dbo_d   = pick_b ? b_dbo : a_dbo;
                    s_req_d   = 1'b1;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmo_cnt_d = '0;
                state_d   = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                // A real ack on the expiry cycle takes precedence over the timeout.
                if (s_ack) begin
                    finish = 1'b1;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    finish        = 1'b1;
                    finish_data   = 8'hFF;
                    timeout_err_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 10'd1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (finish) begin
            s_req_d   = 1'b0;
            s_adr_d   = '0;
            s_dbo_d   = '0;
            gap_cnt_d = '0;
            state_d   = ST_GAP;
            if (grant_b_q) begin
                b_ack_d = 1'b1;
                b_dbi_d = finish_data;
            end else begin
                a_ack_d = 1'b1;
                a_dbi_d = finish_data;
            end
        end
    end

    always_ff @(posedge clk21m) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            s_req_q       <= 1'b0;
            s_wrt_q       <= 1'b0;
            s_adr_q       <= '0;
            s_dbo_q       <= '0;
            a_ack_q       <= 1'b0;
            b_ack_q       <= 1'b0;
            a_dbi_q       <= '0;
            b_dbi_q       <= '0;
            grant_b_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            tmo_cnt_q     <= '0;
            gap_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            s_req_q       <= s_req_d;
            s_wrt_q       <= s_wrt_d;
            s_adr_q       <= s_adr_d;
            s_dbo_q       <= s_dbo_d;
            a_ack_q       <= a_ack_d;
            b_ack_q       <= b_ack_d;
            a_dbi_q       <= a_dbi_d;
            b_dbi_q       <= b_dbi_d;
            grant_b_q     <= grant_b_d;
            timeout_err_q <= timeout_err_d;
            tmo_cnt_q     <= tmo_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
        end
    end

    assign s_req       = s_req_q;
    assign s_wrt       = s_wrt_q;
    assign s_adr       = s_adr_q;
    assign s_dbo       = s_dbo_q;
    assign a_ack       = a_ack_q;
    assign b_ack       = b_ack_q;
    assign a_dbi       = a_dbi_q;
    assign b_dbi       = b_dbi_q;
    assign grant_b     = grant_b_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_scc_bus_arbiter.sv
// Self-checking bench for scc_bus_arbiter: directed scenarios plus randomized accesses
// checked against a transaction-level model of grant order, timing and returned data.
module tb_scc_bus_arbiter;

    localparam int GAP = 8;
    localparam int TMO = 64;

    logic        clk21m = 1'b0;
    logic        reset;
    logic        a_req, a_wrt, b_req, b_wrt;
    logic [15:0] a_adr, b_adr;
    logic [7:0]  a_dbo, b_dbo;
    logic        a_ack, b_ack;
    logic [7:0]  a_dbi, b_dbi;
    logic        s_req, s_wrt;
    logic [15:0] s_adr;
    logic [7:0]  s_dbo;
    logic        s_ack;
    logic [7:0]  s_dbi;
    logic        grant_b, busy, timeout_err;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Transaction-level model state
    logic [7:0] a_dbi_m, b_dbi_m;
    bit         last_b_m;
    int         expect_rise = -1;
    bit         grant_seen;

    scc_bus_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk21m(clk21m), .reset(reset),
        .a_req(a_req), .a_wrt(a_wrt), .a_adr(a_adr), .a_dbo(a_dbo), .a_ack(a_ack), .a_dbi(a_dbi),
        .b_req(b_req), .b_wrt(b_wrt), .b_adr(b_adr), .b_dbo(b_dbo), .b_ack(b_ack), .b_dbi(b_dbi),
        .s_req(s_req), .s_wrt(s_wrt), .s_adr(s_adr), .s_dbo(s_dbo), .s_ack(s_ack), .s_dbi(s_dbi),
        .grant_b(grant_b), .busy(busy), .timeout_err(timeout_err)
    );

    always #23 clk21m = ~clk21m;
    always @(posedge clk21m) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk21m);
        #1;
    endtask

    // Called in an IDLE cycle with the requests for that cycle already driven.
    // ack_dly: cycles from s_req rising until the SCC acks (> TMO means never).
    task automatic access(input int ack_dly, input logic [7:0] rdata, input bit hold);
        bit          exp_b, tmo;
        logic [15:0] ea;
        logic [7:0]  ed, ev;
        logic        ew;
        int          n;
        chk("idle_busy", 32'(busy), 0);
        chk("idle_sreq", 32'(s_req), 0);
        if (a_req && b_req) begin
`ifdef SCC_ARB_ROUND_ROBIN_EN
            exp_b = !last_b_m;
`else
            exp_b = 1'b0;
`endif
        end else begin
            exp_b = b_req;
        end
        last_b_m = exp_b;
        ea  = exp_b ? b_adr : a_adr;
        ed  = exp_b ? b_dbo : a_dbo;
        ew  = exp_b ? b_wrt : a_wrt;
        tmo = (ack_dly > TMO);
        n   = tmo ? 1 + TMO : 1 + ack_dly;
        ev  = tmo ? 8'hFF : rdata;

        step();
        if (expect_rise >= 0) chk("rise_spacing", 32'(cyc), 32'(expect_rise));
        expect_rise = -1;
        grant_seen = grant_b;
        chk("issue_sreq", 32'(s_req), 1);
        chk("issue_busy", 32'(busy), 1);
        chk("issue_grant_b", 32'(grant_b), 32'(exp_b));
        chk("issue_adr", 32'(s_adr), 32'(ea));
        chk("issue_wrt", 32'(s_wrt), 32'(ew));
        chk("issue_dbo", 32'(s_dbo), 32'(ed));

        for (int c = 2; c <= n; c++) begin
            step();
            chk("wait_sreq", 32'(s_req), 1);
            chk("wait_adr", 32'(s_adr), 32'(ea));
            chk("wait_noack", 32'({a_ack, b_ack}), 0);
            s_ack = (c == 1 + ack_dly);
            s_dbi = s_ack ? rdata : 8'($urandom);
        end

        step();
        s_ack = 1'b0;
        if (exp_b) b_dbi_m = ev; else a_dbi_m = ev;
        chk("done_sreq", 32'(s_req), 0);
        chk("done_a_ack", 32'(a_ack), 32'(!exp_b));
        chk("done_b_ack", 32'(b_ack), 32'(exp_b));
        chk("done_a_dbi", 32'(a_dbi), 32'(a_dbi_m));
        chk("done_b_dbi", 32'(b_dbi), 32'(b_dbi_m));
        chk("done_tmo_err", 32'(timeout_err), 32'(tmo));
        chk("done_grant_b", 32'(grant_b), 32'(exp_b));
        chk("gap_adr", 32'(s_adr), 0);
        chk("gap_dbo", 32'(s_dbo), 0);
        if (!hold) begin
            if (exp_b) b_req = 1'b0; else a_req = 1'b0;
        end

        for (int g = 1; g < GAP; g++) begin
            step();
            chk("gap_busy", 32'(busy), 1);
            chk("gap_sreq", 32'(s_req), 0);
            if (g == 1) chk("gap_pulse_end", 32'({a_ack, b_ack, timeout_err}), 0);
        end
        chk("gap_grant_held", 32'(grant_b), 32'(exp_b));

        step();
        chk("reidle_busy", 32'(busy), 0);
        if (hold) expect_rise = cyc + 1;
    endtask

    initial begin
        logic [3:0] tie_exp;
        logic [1:0] r;
        int         dly;
`ifdef SCC_ARB_ROUND_ROBIN_EN
        tie_exp = 4'b1010;
`else
        tie_exp = 4'b0000;
`endif
        reset = 1'b1;
        a_req = 0; a_wrt = 0; a_adr = 0; a_dbo = 0;
        b_req = 0; b_wrt = 0; b_adr = 0; b_dbo = 0;
        s_ack = 0; s_dbi = 0;
        a_dbi_m = 0; b_dbi_m = 0; last_b_m = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        chk("rst_outputs", 32'({a_ack, b_ack, s_req, s_wrt, grant_b, busy, timeout_err}), 0);
        chk("rst_s_adr", 32'(s_adr), 0);
        chk("rst_s_dbo", 32'(s_dbo), 0);
        chk("rst_dbi", 32'({a_dbi, b_dbi}), 0);

        // A write 0x9000 = 0x3F, ack two cycles after s_req
        a_req = 1; a_wrt = 1; a_adr = 16'h9000; a_dbo = 8'h3F;
        access(2, 8'h00, 0);
        $display("txn A write 9000=3F done cycle %0d", cyc);

        // B read 0x9810 returning 0x7F
        b_req = 1; b_wrt = 0; b_adr = 16'h9810; b_dbo = 8'h00;
        access(1, 8'h7F, 0);
        chk("b_read_dbi", 32'(b_dbi), 32'h7F);
        chk("b_read_a_dbi_kept", 32'(a_dbi), 0);
        $display("txn B read 9810 -> %0h", b_dbi);

        // Simultaneous requests, four rounds
        for (int i = 0; i < 4; i++) begin
            a_req = 1; a_wrt = 1; a_adr = 16'h9000 + 16'(i); a_dbo = 8'(i);
            if (!b_req) begin
                b_req = 1; b_wrt = 0; b_adr = 16'h9880; b_dbo = 8'h00;
            end
            access(2, 8'h10 + 8'(i), 0);
            chk("tie_order", 32'(grant_seen), 32'(tie_exp[i]));
            $display("txn tie round %0d granted %s", i, grant_seen ? "B" : "A");
        end
        for (int k = 0; k < 4; k++) begin
            if (a_req || b_req) begin
                access(1, 8'h33, 0);
                $display("txn drain granted %s", grant_seen ? "B" : "A");
            end
        end

        // SCC never acks: timeout
        a_req = 1; a_wrt = 0; a_adr = 16'h9820; a_dbo = 0;
        access(1000, 8'h00, 0);
        chk("tmo_dbi_ff", 32'(a_dbi), 32'hFF);
        $display("txn A timeout a_dbi=%0h", a_dbi);

        // Ack on the expiry cycle wins over the timeout
        a_req = 1; a_wrt = 0; a_adr = 16'h9821;
        access(TMO, 8'h5A, 0);
        $display("txn A ack at expiry a_dbi=%0h", a_dbi);

        // Reset during WAIT_ACK
        a_req = 1; a_wrt = 0; a_adr = 16'h9800;
        repeat (3) step();
        chk("pre_rst_sreq", 32'(s_req), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        a_req = 0;
        a_dbi_m = 0; b_dbi_m = 0; last_b_m = 1'b1;
        chk("midrst_sreq", 32'(s_req), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_a_ack", 32'(a_ack), 0);
        chk("midrst_a_dbi", 32'(a_dbi), 0);
        repeat (3) begin
            step();
            chk("post_rst_quiet", 32'({a_ack, b_ack, s_req, busy}), 0);
        end
        a_req = 1; a_wrt = 0; a_adr = 16'h9801;
        access(3, 8'hA5, 0);
        $display("txn after reset a_dbi=%0h", a_dbi);

        // Back-to-back A with req held high
        a_req = 1; a_wrt = 1; a_adr = 16'h9830; a_dbo = 8'hC3;
        access(3, 8'h01, 1);
        access(1, 8'h02, 1);
        access(2, 8'h03, 0);
        $display("txn back-to-back A done cycle %0d", cyc);

        // Randomized mix
        for (int i = 0; i < 24; i++) begin
            r = 2'($urandom_range(1, 3));
            if (!a_req && r[0]) begin
                a_req = 1; a_wrt = 1'($urandom); a_adr = 16'($urandom); a_dbo = 8'($urandom);
            end
            if (!b_req && r[1]) begin
                b_req = 1; b_wrt = 1'($urandom); b_adr = 16'($urandom); b_dbo = 8'($urandom);
            end
            dly = ($urandom_range(0, 7) == 0) ? TMO + 5 : $urandom_range(1, 5);
            access(dly, 8'($urandom), 0);
            $display("txn rand %0d granted %s dly %0d a_dbi=%0h b_dbi=%0h",
                     i, grant_seen ? "B" : "A", dly, a_dbi, b_dbi);
        end
        for (int k = 0; k < 4; k++) begin
            if (a_req || b_req) access(2, 8'h44, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/scc_bus_arbiter.md
Name: scc_bus_arbiter

Overview:
- Shares the single SCC register/wave-RAM bus port (req/ack/wrt/adr/dbo/dbi) of scc_for_ocm between two requesters: A (MSX CPU slot bus) and B (on-chip register player/sequencer).
- Captures each request, issues one downstream access and holds s_req until s_ack. Returns read data and a one-cycle ack to the granted requester, then enforces a recovery gap.
- Includes an ack timeout so a stalled SCC cannot hang either requester.

Parameters:
- GAP_CYCLES, 8, idle cycles after each completed access before the next grant (1..255)
- TIMEOUT_CYCLES, 64, cycles in WAIT_ACK before abort (2..1023)

Ports:
- clk21m  in  1  21.47727 MHz clock
- reset  in  1  synchronous, active-high reset
- a_req  in  1  requester A request level; a_wrt/a_adr/a_dbo stable while high
- a_wrt  in  1  A: 1=write, 0=read
- a_adr  in  16  A address
- a_dbo  in  8  A write data
- a_ack  out  1  A completion pulse, one cycle
- a_dbi  out  8  A read data, valid from a_ack, held until next A completion
- b_req, b_wrt, b_adr, b_dbo, b_ack, b_dbi: same directions, widths and meanings as the A ports, for requester B
- s_req  out  1  to SCC req
- s_wrt  out  1  to SCC wrt
- s_adr  out  16  to SCC adr
- s_dbo  out  8  to SCC dbo
- s_ack  in  1  from SCC ack
- s_dbi  in  8  from SCC dbi
- grant_b  out  1  1 while the current/last access belongs to B
- busy  out  1  1 in any state other than IDLE
- timeout_err  out  1  one-cycle pulse on ack timeout

Behaviour:
- Reset values: all outputs 0; s_adr=0, s_dbo=0, a_dbi=b_dbi=0; state IDLE; last-grant=B, so A wins the first tie. Reset mid-access aborts it: s_req drops the next cycle and no x_ack is issued.
- States:
  - IDLE: if either req is high, select a winner and latch its wrt/adr/dbo into s_* registers, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE (1 cycle): s_req=1, then go to WAIT_ACK.
  - WAIT_ACK: s_req held at 1. When s_ack=1, latch s_dbi into the winner's x_dbi, pulse the winner's x_ack and set s_req=0 the next cycle, then go to GAP.
  - GAP: s_req=0 for GAP_CYCLES cycles, then return to IDLE.
- Latency: x_req high in cycle 0 gives s_req=1 in cycle 1. If s_ack is sampled high in cycle n, x_ack=1 in cycle n+1. The earliest next grant is cycle n+1+GAP_CYCLES.
- Writes also complete only on s_ack. x_dbi is updated for writes too, with the s_dbi value at ack (don't-care to requesters).
- x_req is ignored outside IDLE. A requester must drop req within GAP_CYCLES after its x_ack. A req still high when IDLE is re-entered counts as a new request.
- Arbitration: a single request is granted immediately. For simultaneous requests, see Optional Feature. A losing request stays pending, with no starvation under round-robin.
- s_wrt/s_adr/s_dbo are stable from ISSUE through the ack cycle. s_adr and s_dbo return to 0 in GAP.
- Timeout: a 10-bit counter cleared in ISSUE and incremented in WAIT_ACK. Reaching TIMEOUT_CYCLES without s_ack causes the following:
  - s_req drops.
  - The winner gets x_ack with x_dbi=8'hFF.
  - timeout_err pulses.
  - State goes to GAP.
- If s_ack coincides with expiry, the ack wins: normal completion, no timeout_err.
- grant_b is updated at grant and held through GAP.

Optional Feature:
- Macro SCC_ARB_ROUND_ROBIN_EN.
- Defined: on a tie, grant the requester not granted last; the last-grant register is updated at every grant.
- Undefined: fixed priority, A always wins ties and B may starve; the last-grant register is not built.

Test Plan:
- A write 0x9000=0x3F, s_ack returned 2 cycles after s_req -> s_req high 3 cycles with s_adr=0x9000, s_wrt=1, s_dbo=0x3F; a_ack 1 cycle later; b_ack never.
- B read 0x9810, SCC returns s_dbi=0x7F with s_ack -> b_dbi=0x7F at b_ack, grant_b=1, a_dbi unchanged (0).
- A and B requesting in the same cycle, repeated 4 times with ROUND_ROBIN_EN -> grant order A,B,A,B. Without it -> A,A,A,A, with B served only once A is idle.
- s_ack held 0 -> s_req drops after 64 cycles in WAIT_ACK, a_ack with a_dbi=0xFF, timeout_err one-cycle pulse; next grant 8 cycles later.
- Reset asserted during WAIT_ACK -> next cycle s_req=0, busy=0, no a_ack; a fresh request afterwards completes normally.
- Back-to-back A requests with req held high -> consecutive s_req rising edges spaced at least GAP_CYCLES+2 cycles apart; busy low for exactly 1 cycle between them.
